alu_share_arbiter: RTL

Shares the single 16-bit ALU between two independent requesters (e.g. the instruction datapath and a DMA/address-generation unit) using valid/ready handshakes on both request and response sides. Accepts one operation at a time, registers the operands, drives the ALU for one cycle, captures result and Zero, and returns them to the owning requester with backpressure support. Sits between the requesters and the combinational ALU; the ALU instance is external and wired to the `alu_*` ports.

---
 rtl/alu_share_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester valid/ready front end for one shared 16-bit ALU
//
// Purpose:
//   Accepts one ALU operation at a time from either of two requesters, registers
//   the operands, presents them to the external combinational ALU for one cycle,
//   captures result/Zero and returns them to the requester that issued the op.
//   Sequence per op: IDLE (accept) -> EXEC (ALU driven) -> RESP (held until taken).
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   : round-robin tie-break; pointer flips away from the
//                              requester whose response just completed.
//                  undefined : fixed priority, requester 0 wins ties.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/req0_ready         requester 0 request handshake
//   req0_a, req0_b, req0_op       operands and opcode
//   req0_dir                      shift direction (1 = right)
//   rsp0_valid/rsp0_ready         requester 0 response handshake
//   rsp0_result, rsp0_zero        returned result and Zero flag
//   req1_*, rsp1_*                same set for requester 1
//   alu_a, alu_b, alu_op          ALU operand/opcode inputs
//   alu_one_zero                  ALU direction input (latched req dir)
//   alu_result, alu_zero          ALU outputs
//   busy                          high whenever not IDLE
//   owner                         index of the requester currently granted

module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req0_dir,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              req1_dir,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_one_zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Opcode that makes the ALU output a constant zero; parked on the bus
    // outside EXEC so the ALU does not toggle while idle or stalled.
    localparam logic [OP_W-1:0] OP_ZERO = OP_W'(6);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic              r_dir;
    logic              r_owner;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;

    logic w_idle;
    logic w_sel1;
    logic w_accept;
    logic w_rsp_done;

    assign w_idle = (r_state == S_IDLE);

`ifdef ALU_ARB_RR_EN
    logic r_ptr;

    // Requester 1 wins when it is the only one asking, or on a tie when the
    // pointer favours it.
    assign w_sel1 = req1_valid && (!req0_valid || r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_rsp_done) begin
            r_ptr <= ~r_owner;
        end
    end
`else
    assign w_sel1 = req1_valid && !req0_valid;
`endif

    // Only the selected requester ever sees ready, and only in IDLE.
    assign req0_ready = w_idle && req0_valid && !w_sel1;
    assign req1_ready = w_idle && w_sel1;
    assign w_accept   = w_idle && (req0_valid || req1_valid);

    assign w_rsp_done = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ZERO;
            r_dir    <= 1'b0;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel1 ? req1_a   : req0_a;
                        r_b     <= w_sel1 ? req1_b   : req0_b;
                        r_op    <= w_sel1 ? req1_op  : req0_op;
                        r_dir   <= w_sel1 ? req1_dir : req0_dir;
                        r_owner <= w_sel1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_result;
                    r_zero   <= alu_zero;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand lines keep their last latched value; only the opcode is gated.
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_one_zero = r_dir;
    assign alu_op       = (r_state == S_EXEC) ? r_op : OP_ZERO;

    assign rsp0_valid  = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == S_RESP) &&  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;

    assign busy  = !w_idle;
    assign owner = r_owner;

endmodule
